// File: rtl/seg_value_formatter_if.sv
// Bus between a requester and the 7-segment value formatter: request fields in, formatted digits out.
interface seg_value_formatter_if;
  logic        start;
  logic [31:0] value;
  logic [4:0]  radix_in;
  logic        signed_mode;
  logic [31:0] seg_data;
  logic [4:0]  radix;
  logic        busy;
  logic        done;
  logic        overflow;

  // Requester side: issues start/value, observes the formatted result.
  modport master (
    output start, value, radix_in, signed_mode,
    input  seg_data, radix, busy, done, overflow
  );

  // Formatter side.
  modport slave (
    input  start, value, radix_in, signed_mode,
    output seg_data, radix, busy, done, overflow
  );
endinterface

// File: rtl/seg_value_formatter.sv
// Formats a 32-bit value for the 7-segment decoder: hex pass-through in one
// cycle, or a fixed-latency 32-step double-dabble to 8 BCD digits with an
// optional minus sign (nibble F) and an all-dashes overflow pattern.
module seg_value_formatter (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_value_formatter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIN} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_mag;
  logic [31:0] r_bcd;
  logic        r_neg;
  logic        r_ovf_pend;
  logic [4:0]  r_cnt;
  logic [31:0] r_seg_data;
  logic [4:0]  r_radix;
  logic        r_done;
  logic        r_overflow;

  logic        w_busy;
  logic        w_accept;
  logic        w_is_dec;
  logic        w_neg;
  logic [31:0] w_mag;
  logic        w_ovf;
  logic [31:0] w_bcd_adj;

  // Magnitude and overflow are decided at capture so CONV only has to shift.
  // The negative limit is one digit shorter: the top digit carries the sign.
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_is_dec = (bus.radix_in == 5'd10);
  assign w_neg    = bus.signed_mode && bus.value[31];
  assign w_mag    = w_neg ? (~bus.value + 32'd1) : bus.value;
  assign w_ovf    = w_neg ? (w_mag > 32'd9_999_999) : (w_mag > 32'd99_999_999);

  // Add-3 correction for each BCD digit before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                  ? (r_bcd[4*gi +: 4] + 4'd3)
                                  : r_bcd[4*gi +: 4];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: only a decimal request leaves IDLE; CONV runs exactly 32 cycles.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_dec) w_state_next = S_CONV;
      S_CONV:  if (r_cnt == 5'd31)       w_state_next = S_FIN;
      S_FIN:                             w_state_next = S_IDLE;
      default:                           w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs: busy covers CONV and FIN.
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_CONV:  w_busy = 1'b1;
      S_FIN:   w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Datapath: capture, shift-and-add-3 iterations, and result write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mag      <= 32'd0;
      r_bcd      <= 32'd0;
      r_neg      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_cnt      <= 5'd0;
      r_seg_data <= 32'd0;
      r_radix    <= 5'd16;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_dec) begin
              r_mag      <= w_mag;
              r_neg      <= w_neg;
              r_ovf_pend <= w_ovf;
              r_bcd      <= 32'd0;
              r_cnt      <= 5'd0;
            end else begin
              r_seg_data <= bus.value;
              r_radix    <= 5'd16;
              r_overflow <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        S_CONV: begin
          r_bcd <= {w_bcd_adj[30:0], r_mag[31]};
          r_mag <= {r_mag[30:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIN: begin
          if (r_ovf_pend) begin
            r_seg_data <= 32'hFFFF_FFFF;
            r_overflow <= 1'b1;
          end else if (r_neg) begin
            r_seg_data <= {4'hF, r_bcd[27:0]};
            r_overflow <= 1'b0;
          end else begin
            r_seg_data <= r_bcd;
            r_overflow <= 1'b0;
          end
          r_radix <= 5'd10;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.seg_data = r_seg_data;
  assign bus.radix    = r_radix;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_seg_value_formatter.sv
// Directed bench for seg_value_formatter: hex pass-through, decimal
// conversions with boundaries, protocol corner cases and mid-conversion reset.
module tb_seg_value_formatter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seg_value_formatter_if bus ();

  seg_value_formatter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request: drive start for one edge, then wait (bounded) for done.
  task automatic xact(input string tag, input logic [31:0] v, input logic [4:0] rad,
                      input logic sm, input logic [31:0] exp_seg, input logic [4:0] exp_rad,
                      input logic exp_ovf, input int exp_lat);
    int   n;
    int   nbusy;
    logic seen;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.value       = v;
    bus.radix_in    = rad;
    bus.signed_mode = sm;
    @(posedge clk);
    n = 0; nbusy = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    check({tag, " seg_data"}, bus.seg_data, exp_seg);
    check({tag, " radix"}, 32'(bus.radix), 32'(exp_rad));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    $display("[TB] %s value=%h radix_in=%0d signed=%0b -> seg=%h radix=%0d ovf=%0b lat=%0d",
             tag, v, rad, sm, bus.seg_data, bus.radix, bus.overflow, n);
  endtask

  initial begin
    int   n;
    int   ndone;
    int   first_done;
    logic seen;

    n_tests = 0;
    n_fail  = 0;
    bus.start       = 1'b0;
    bus.value       = 32'd0;
    bus.radix_in    = 5'd16;
    bus.signed_mode = 1'b0;
    rst_n           = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset seg_data", bus.seg_data, 32'd0);
    check("reset radix", 32'(bus.radix), 32'd16);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);
    $display("[TB] reset seg=%h radix=%0d", bus.seg_data, bus.radix);
    rst_n = 1'b1;

    // Hex pass-through, then a non-10 radix with signed_mode set (ignored)
    xact("hex",        32'h1234ABCD, 5'd16, 1'b0, 32'h1234ABCD, 5'd16, 1'b0, 1);
    xact("hex_r7_sm",  32'h80000000, 5'd7,  1'b1, 32'h80000000, 5'd16, 1'b0, 1);

    // Decimal unsigned / signed
    xact("dec_12345678", 32'd12_345_678, 5'd10, 1'b0, 32'h12345678, 5'd10, 1'b0, 34);
    xact("dec_zero",     32'd0,          5'd10, 1'b0, 32'h00000000, 5'd10, 1'b0, 34);
    xact("dec_neg42",    32'hFFFFFFD6,   5'd10, 1'b1, 32'hF0000042, 5'd10, 1'b0, 34);
    xact("dec_u_big",    32'hFFFFFFD6,   5'd10, 1'b0, 32'hFFFFFFFF, 5'd10, 1'b1, 34);
    xact("dec_s_pos255", 32'd255,        5'd10, 1'b1, 32'h00000255, 5'd10, 1'b0, 34);

    // Boundaries
    xact("dec_u_max",    32'd99_999_999,  5'd10, 1'b0, 32'h99999999, 5'd10, 1'b0, 34);
    xact("dec_u_ovf",    32'd100_000_000, 5'd10, 1'b0, 32'hFFFFFFFF, 5'd10, 1'b1, 34);
    xact("dec_s_min",    32'hFF676981,    5'd10, 1'b1, 32'hF9999999, 5'd10, 1'b0, 34);
    xact("dec_s_ovf",    32'hFF676980,    5'd10, 1'b1, 32'hFFFFFFFF, 5'd10, 1'b1, 34);
    xact("dec_s_80000000", 32'h80000000,  5'd10, 1'b1, 32'hFFFFFFFF, 5'd10, 1'b1, 34);

    // Second start during CONV is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.value = 32'd87_654_321; bus.radix_in = 5'd10; bus.signed_mode = 1'b0;
    @(posedge clk);
    ndone = 0; first_done = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 5) begin
        bus.start = 1'b1; bus.value = 32'h00000555; bus.radix_in = 5'd16;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (first_done == 0) first_done = i;
      end
    end
    check("ignore done_count", 32'(ndone), 32'd1);
    check("ignore latency", 32'(first_done), 32'd34);
    check("ignore seg_data", bus.seg_data, 32'h87654321);
    check("ignore radix", 32'(bus.radix), 32'd10);
    $display("[TB] ignore_start seg=%h dones=%0d first_done=%0d", bus.seg_data, ndone, first_done);

    // Start in the done cycle is accepted
    @(negedge clk);
    bus.start = 1'b1; bus.value = 32'd4321; bus.radix_in = 5'd10; bus.signed_mode = 1'b0;
    @(posedge clk);
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("donecyc latency", 32'(n), 32'd34);
    check("donecyc first seg", bus.seg_data, 32'h00004321);
    bus.start = 1'b1; bus.value = 32'hCAFE0001; bus.radix_in = 5'd16;
    @(negedge clk);
    bus.start = 1'b0;
    check("donecyc second done", 32'(bus.done), 32'd1);
    check("donecyc second seg", bus.seg_data, 32'hCAFE0001);
    check("donecyc second radix", 32'(bus.radix), 32'd16);
    $display("[TB] start_in_done seg=%h radix=%0d done=%0b", bus.seg_data, bus.radix, bus.done);

    // Reset mid-conversion
    @(negedge clk);
    bus.start = 1'b1; bus.value = 32'd12_345_678; bus.radix_in = 5'd10;
    @(posedge clk);
    ndone = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) ndone++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst seg_data", bus.seg_data, 32'd0);
    check("midrst radix", 32'(bus.radix), 32'd16);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("midrst no_done", 32'(ndone), 32'd0);
    $display("[TB] mid_reset seg=%h radix=%0d dones=%0d", bus.seg_data, bus.radix, ndone);
    xact("after_rst_7", 32'd7, 5'd10, 1'b0, 32'h00000007, 5'd10, 1'b0, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_value_formatter.md
# seg_value_formatter

Sequential formatter directly upstream of the 7-segment digit decoder. It captures a 32-bit value on a start pulse and produces the 8-nibble `seg_data` word and matching `radix` code that the decoder consumes.
- Hex mode passes the value through in one cycle.
- Decimal mode runs a 32-step shift-and-add-3 (double-dabble) conversion to 8 BCD digits, with optional sign handling.
- Nibble `4'hF` is the minus sign in decimal mode; `0xFFFFFFFF` (all dashes) flags overflow.

## Interface
Parameters: none.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `value`  in  32  operand, captured on accepted start
- `radix_in`  in  5  `5'd10` selects decimal; any other value is treated as hex (16)
- `signed_mode`  in  1  decimal only: `value` is two's complement; captured with start
- `seg_data`  out  32  nibble `[4i+3:4i]` = digit i, digit 0 rightmost; held between results
- `radix`  out  5  `5'd10` or `5'd16`; updated together with `seg_data`
- `busy`  out  1  high while a decimal conversion is in progress
- `done`  out  1  one-cycle pulse; `seg_data`/`radix`/`overflow` are valid in this cycle
- `overflow`  out  1  last result did not fit; held with `seg_data`

## Operation
- States:
  - IDLE: accepts start.
  - CONV: 32 iteration cycles, decimal only.
  - FIN: output write, decimal only.
- Start accepted only in IDLE; start during CONV/FIN is ignored with no side effects. Start in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- Hex path, start in IDLE with `radix_in != 10`:
  - Next edge: `seg_data <= value`, `radix <= 16`, `overflow <= 0`, `done <= 1`.
  - FSM stays in IDLE; `busy` never rises. `signed_mode` is ignored.
- Decimal path, start with `radix_in == 10`:
  - Capture magnitude `mag` = `signed_mode && value[31]` ? `-value` : `value` (32-bit unsigned; `0x80000000` gives mag `0x80000000`).
  - Capture `neg` = `signed_mode && value[31]`.
  - Clear the 32-bit BCD accumulator; set the iteration counter to 0; go to CONV.
  - Each CONV cycle: add 3 to every BCD nibble ≥ 5, then shift `{bcd, mag}` left by 1.
  - After the 32nd shift (counter 31), go to FIN.
- Overflow limits, computed at capture and registered:
  - Unsigned (`!neg`): overflow if `mag > 99_999_999`.
  - Negative (`neg`): overflow if `mag > 9_999_999`, since the top digit is reserved for the sign.
  - `bcd` holds the low 8 decimal digits of `mag` (wrap-around when `mag` is too large); `seg_data` still shows all dashes on overflow, but the conversion still runs the full 32 cycles so latency is fixed.
- FIN, one cycle:
  - Overflow: `seg_data <= 32'hFFFF_FFFF`, `overflow <= 1`.
  - Else if `neg`: `seg_data <= {4'hF, bcd[27:0]}`, `overflow <= 0`.
  - Else: `seg_data <= bcd`, `overflow <= 0`.
  - In all cases `radix <= 10`, `done <= 1`; go to IDLE.
- No leading-zero suppression; unused digits show 0.
- Zero is never shown with a sign (`-0` is impossible: `neg` implies `mag ≠ 0`).

## Timing
- Reset values (first edge with `rst_n = 0`):
  - `seg_data = 0`, `radix = 5'd16`, `busy = 0`, `done = 0`, `overflow = 0`
  - FSM = IDLE, counter = 0, internal registers cleared.
- Reset has priority over every other action, including mid-CONV. An in-flight conversion is discarded and does not produce `done`.
- Hex latency: start sampled at edge k; `done` high in cycle k+1.
- Decimal latency: start sampled at edge k.
  - `busy` is high cycles k+1 … k+33 (CONV k+1..k+32, FIN k+33).
  - Outputs update and `done` is high in cycle k+34; `busy` is low in that cycle.
- `done` is high for exactly one cycle per accepted start.
- Outputs change only on `done` or reset.
- Back-to-back: with start held high continuously in decimal mode, a new conversion is accepted every 34 cycles.

## Test plan
- Reset, then hex: `value = 0x1234ABCD`, `radix_in = 16`, start → `done` 1 cycle later, `seg_data = 0x1234ABCD`, `radix = 16`, `overflow = 0`, `busy` never high.
- Decimal unsigned:
  - `value = 12_345_678` → `busy` for 33 cycles, then `done` with `seg_data = 0x12345678`, `radix = 10`.
  - `value = 0` → `seg_data = 0x00000000`.
- Decimal signed:
  - `value = 0xFFFFFFD6` (−42), `signed_mode = 1` → `seg_data = 0xF0000042`.
  - Same value with `signed_mode = 0` → overflow (4294967254 > 99_999_999), `seg_data = 0xFFFFFFFF`.
- Boundaries:
  - Unsigned `99_999_999` → `0x99999999`, `overflow = 0`.
  - Unsigned `100_000_000` → `0xFFFFFFFF`, `overflow = 1`.
  - Signed −9_999_999 → `0xF9999999`.
  - Signed −10_000_000 → overflow.
  - Signed `0x80000000` → overflow.
- Protocol:
  - Second start at cycle 5 of a conversion → ignored; the first result is unchanged and only one `done` is seen.
  - Start asserted in the `done` cycle → accepted.
- Reset mid-conversion: assert `rst_n = 0` at CONV cycle 10 → all outputs at reset values next cycle and no `done`. A subsequent start with `value = 7` returns `seg_data = 0x00000007` after 34 cycles.
